// File: rtl/address_sequencer_pkg.sv
// Shared definitions for the convolution-tile address sequencer: default widths,
// state encoding and the invalid-slot address pattern.
package address_sequencer_pkg;

    localparam int ROW_WIDTH_DEF = 10;
    localparam int COL_WIDTH_DEF = 11;
    localparam int CH_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Invalid slot: MSB set, payload cleared; caller casts to its own width
    function automatic logic [31:0] invalid_addr(input int unsigned width);
        return 32'd1 << (width - 32'd1);
    endfunction

endpackage

// File: rtl/address_sequencer_if.sv
// Address beat bus towards the lane address pipeline: one row/col/ch triple per
// accepted cycle, valid/ready handshake.
interface address_sequencer_if
    import address_sequencer_pkg::*;
#(
    parameter int row_width = ROW_WIDTH_DEF,
    parameter int col_width = COL_WIDTH_DEF,
    parameter int ch_width  = CH_WIDTH_DEF
) ();

    logic [row_width-1:0] row_addr;
    logic [col_width-1:0] col_addr;
    logic [ch_width-1:0]  ch_addr;
    logic                 addr_valid;
    logic                 out_ready;

    modport master (
        output row_addr,
        output col_addr,
        output ch_addr,
        output addr_valid,
        input  out_ready
    );

    modport slave (
        input  row_addr,
        input  col_addr,
        input  ch_addr,
        input  addr_valid,
        output out_ready
    );

endinterface

// File: rtl/address_sequencer_wrap_counter.sv
// Index counter that wraps to zero after reaching a programmable limit; chained
// through at_max to build the ch/col/row nest.
module wrap_counter #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [width-1:0] limit,
    output logic [width-1:0] value,
    output logic [width-1:0] value_next,
    output logic             at_max
);

    logic [width-1:0] value_r;
    logic [width-1:0] value_next_s;
    logic             at_max_s;

    assign at_max_s = (value_r == limit);

    // Next index: clear wins, otherwise wrap at the limit or step by one
    always_comb begin
        value_next_s = value_r;
        if (clear) begin
            value_next_s = {width{1'b0}};
        end else if (inc && at_max_s) begin
            value_next_s = {width{1'b0}};
        end else if (inc) begin
            value_next_s = value_r + width'(1);
        end else begin
            value_next_s = value_r;
        end
    end

    // Index register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_r <= {width{1'b0}};
        end else begin
            value_r <= value_next_s;
        end
    end

    assign value      = value_r;
    assign value_next = value_next_s;
    assign at_max     = at_max_s;

endmodule

// File: rtl/address_sequencer.sv
// Tile address sequencer: walks ch (innermost), col, row over a latched tile
// configuration and presents one registered address beat per accepted cycle.
module address_sequencer
    import address_sequencer_pkg::*;
#(
    parameter int row_width = ROW_WIDTH_DEF,
    parameter int col_width = COL_WIDTH_DEF,
    parameter int ch_width  = CH_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [row_width-2:0] cfg_rows,
    input  logic [col_width-2:0] cfg_cols,
    input  logic [ch_width-2:0]  cfg_chs,
    input  logic                 cfg_stride2,
    address_sequencer_if.master  beat,
    output logic                 busy,
    output logic                 done
);

    localparam int RP = row_width - 1;
    localparam int CP = col_width - 1;
    localparam int HP = ch_width - 1;

    localparam logic [row_width-1:0] ROW_INVALID = row_width'(invalid_addr(row_width));
    localparam logic [col_width-1:0] COL_INVALID = col_width'(invalid_addr(col_width));
    localparam logic [ch_width-1:0]  CH_INVALID  = ch_width'(invalid_addr(ch_width));

    state_t state_r;
    state_t state_next_s;

    logic [RP-1:0] rows_r;
    logic [CP-1:0] cols_r;
    logic [HP-1:0] chs_r;
    logic          stride2_r;

    logic [RP-1:0] row_limit_s, row_idx_s, row_next_s, row_sel_s;
    logic [CP-1:0] col_limit_s, col_idx_s, col_next_s, col_sel_s;
    logic [HP-1:0] ch_limit_s, ch_idx_s, ch_next_s, ch_sel_s;
    logic          row_max_s, col_max_s, ch_max_s;
    logic          col_inc_s, row_inc_s;

    logic accept_s, last_s, hold_s, cnt_clear_s, cfg_zero_s, launch_s;

    logic                 valid_r, busy_r, done_r;
    logic [row_width-1:0] row_addr_r;
    logic [col_width-1:0] col_addr_r;
    logic [ch_width-1:0]  ch_addr_r;

    logic                 valid_next_s, busy_next_s, done_next_s;
    logic [row_width-1:0] row_addr_next_s;
    logic [col_width-1:0] col_addr_next_s;
    logic [ch_width-1:0]  ch_addr_next_s;

    assign launch_s   = (state_r == ST_IDLE) && start && !abort;
    assign cfg_zero_s = (cfg_rows == {RP{1'b0}}) || (cfg_cols == {CP{1'b0}})
                        || (cfg_chs == {HP{1'b0}});
    assign accept_s   = (state_r == ST_RUN) && valid_r && beat.out_ready;
    assign hold_s     = (state_r == ST_RUN) && !accept_s;
    assign last_s     = row_max_s && col_max_s && ch_max_s;
    assign cnt_clear_s = (state_r != ST_RUN) || abort;
    assign col_inc_s  = accept_s && ch_max_s;
    assign row_inc_s  = col_inc_s && col_max_s;

    assign row_limit_s = rows_r - RP'(1);
    assign col_limit_s = cols_r - CP'(1);
    assign ch_limit_s  = chs_r - HP'(1);

    // Configuration shadow, captured only when a tile is launched
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rows_r    <= {RP{1'b0}};
            cols_r    <= {CP{1'b0}};
            chs_r     <= {HP{1'b0}};
            stride2_r <= 1'b0;
        end else if (launch_s) begin
            rows_r    <= cfg_rows;
            cols_r    <= cfg_cols;
            chs_r     <= cfg_chs;
            stride2_r <= cfg_stride2;
        end else begin
            rows_r    <= rows_r;
            cols_r    <= cols_r;
            chs_r     <= chs_r;
            stride2_r <= stride2_r;
        end
    end

    wrap_counter #(.width(HP)) u_ch_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear_s),
        .inc        (accept_s),
        .limit      (ch_limit_s),
        .value      (ch_idx_s),
        .value_next (ch_next_s),
        .at_max     (ch_max_s)
    );

    wrap_counter #(.width(CP)) u_col_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear_s),
        .inc        (col_inc_s),
        .limit      (col_limit_s),
        .value      (col_idx_s),
        .value_next (col_next_s),
        .at_max     (col_max_s)
    );

    wrap_counter #(.width(RP)) u_row_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear_s),
        .inc        (row_inc_s),
        .limit      (row_limit_s),
        .value      (row_idx_s),
        .value_next (row_next_s),
        .at_max     (row_max_s)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort outranks both start and accept
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (start) begin
                    state_next_s = cfg_zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (accept_s && last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: next beat is built from the index the counters will hold
    always_comb begin
        valid_next_s    = (state_next_s == ST_RUN);
        busy_next_s     = (state_next_s != ST_IDLE);
        done_next_s     = (state_r == ST_DONE) && !abort;
        row_sel_s       = hold_s ? row_idx_s : row_next_s;
        col_sel_s       = hold_s ? col_idx_s : col_next_s;
        ch_sel_s        = hold_s ? ch_idx_s : ch_next_s;
        row_addr_next_s = ROW_INVALID;
        col_addr_next_s = COL_INVALID;
        ch_addr_next_s  = CH_INVALID;
        if (valid_next_s) begin
            // Stride 2 doubles the spatial index; overflow simply drops the top bit
            row_addr_next_s = {1'b0, stride2_r ? {row_sel_s[RP-2:0], 1'b0} : row_sel_s};
            col_addr_next_s = {1'b0, stride2_r ? {col_sel_s[CP-2:0], 1'b0} : col_sel_s};
            ch_addr_next_s  = {1'b0, ch_sel_s};
        end else begin
            row_addr_next_s = ROW_INVALID;
            col_addr_next_s = COL_INVALID;
            ch_addr_next_s  = CH_INVALID;
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            row_addr_r <= ROW_INVALID;
            col_addr_r <= COL_INVALID;
            ch_addr_r  <= CH_INVALID;
        end else begin
            valid_r    <= valid_next_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
            row_addr_r <= row_addr_next_s;
            col_addr_r <= col_addr_next_s;
            ch_addr_r  <= ch_addr_next_s;
        end
    end

    assign beat.addr_valid = valid_r;
    assign beat.row_addr   = row_addr_r;
    assign beat.col_addr   = col_addr_r;
    assign beat.ch_addr    = ch_addr_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: tb/tb_address_sequencer.sv
// Self-checking bench for address_sequencer: directed and randomized tiles
// compared against a nested-loop reference of the expected beat stream.
module tb_address_sequencer;
    import address_sequencer_pkg::*;

    localparam int RW = ROW_WIDTH_DEF;
    localparam int CW = COL_WIDTH_DEF;
    localparam int HW = CH_WIDTH_DEF;
    localparam logic [31:0] INV_WORD = 32'h1004_0080;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [RW-2:0] cfg_rows = '0;
    logic [CW-2:0] cfg_cols = '0;
    logic [HW-2:0] cfg_chs = '0;
    logic          cfg_stride2 = 1'b0;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    address_sequencer_if #(.row_width(RW), .col_width(CW), .ch_width(HW)) beat ();

    address_sequencer #(.row_width(RW), .col_width(CW), .ch_width(HW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_rows    (cfg_rows),
        .cfg_cols    (cfg_cols),
        .cfg_chs     (cfg_chs),
        .cfg_stride2 (cfg_stride2),
        .beat        (beat),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] addr_word();
        return {3'b000, beat.row_addr, beat.col_addr, beat.ch_addr};
    endfunction

    // mode: 0 always ready, 1 drop ready 3 cycles at beat 5, 2 random ready
    task automatic run_tile(input int rows, input int cols, input int chs, input bit s,
                            input int mode, input int abort_at, input int start_at,
                            input string tag);
        int  exp_q[$];
        int  n, idx, k, stalls, drops, done_k, mul;
        bit  ready, finished, aborted, restarted;
        mul = s ? 2 : 1;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                for (int h = 0; h < chs; h++)
                    exp_q.push_back((((r * mul) % (1 << (RW - 1))) << 19)
                                    | (((c * mul) % (1 << (CW - 1))) << 8) | h);
        n = rows * cols * chs;
        cfg_rows = (RW - 1)'(rows);
        cfg_cols = (CW - 1)'(cols);
        cfg_chs = (HW - 1)'(chs);
        cfg_stride2 = s;
        beat.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 0; k = 0; stalls = 0; drops = 0; done_k = -1;
        finished = 1'b0; aborted = 1'b0; restarted = 1'b0;
        while (!finished && k < 4 * n + 40) begin
            cfg_rows = (RW - 1)'($urandom);
            cfg_cols = (CW - 1)'($urandom);
            cfg_chs = (HW - 1)'($urandom);
            cfg_stride2 = 1'($urandom);
            if (beat.addr_valid) begin
                if (idx < n) chk({tag, " beat"}, addr_word(), exp_q[idx]);
                else chk({tag, " extra_beat"}, 32'd1, 32'd0);
            end else begin
                chk({tag, " idle_addr"}, addr_word(), INV_WORD);
            end
            if (done) begin
                done_k = k;
                finished = 1'b1;
            end else begin
                chk({tag, " busy"}, 32'(busy), 32'd1);
                case (mode)
                    1: begin
                        ready = !(beat.addr_valid && idx == 5 && drops < 3);
                        if (!ready) drops++;
                    end
                    2: ready = ($urandom_range(0, 3) != 0);
                    default: ready = 1'b1;
                endcase
                if (abort_at >= 0 && beat.addr_valid && idx == abort_at) begin
                    abort = 1'b1;
                    beat.out_ready = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk({tag, " abort_flags"}, {29'd0, beat.addr_valid, busy, done}, 32'd0);
                    chk({tag, " abort_addr"}, addr_word(), INV_WORD);
                    for (int i = 0; i < 3; i++) begin
                        tick();
                        chk({tag, " abort_no_done"}, 32'(done), 32'd0);
                    end
                    aborted = 1'b1;
                    finished = 1'b1;
                end else begin
                    start = (start_at >= 0 && idx == start_at && !restarted);
                    if (start) restarted = 1'b1;
                    beat.out_ready = ready;
                    if (beat.addr_valid && ready) idx++;
                    else if (beat.addr_valid) stalls++;
                    tick();
                    start = 1'b0;
                    k++;
                end
            end
        end
        beat.out_ready = 1'b1;
        if (!finished) begin
            chk({tag, " done_timeout"}, 32'd0, 32'd1);
        end else if (!aborted) begin
            chk({tag, " done_cycle"}, 32'(done_k), 32'(n + 1 + stalls));
            chk({tag, " beat_count"}, 32'(idx), 32'(n));
            tick();
            chk({tag, " done_pulse_end"}, {30'd0, busy, done}, 32'd0);
        end
    endtask

    initial begin
        beat.out_ready = 1'b1;
        tick();
        tick();
        chk("in_reset_valid", 32'(beat.addr_valid), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_valid", 32'(beat.addr_valid), 32'd0);
        chk("rst_row", 32'(beat.row_addr), 32'h200);
        chk("rst_col", 32'(beat.col_addr), 32'h400);
        chk("rst_ch", 32'(beat.ch_addr), 32'h80);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);

        run_tile(2, 2, 3, 1'b0, 0, -1, -1, "stride1");
        run_tile(2, 2, 3, 1'b1, 0, -1, -1, "stride2");
        run_tile(2, 2, 3, 1'b0, 1, -1, -1, "backpressure");
        run_tile(2, 2, 0, 1'b0, 0, -1, -1, "zero_chs");
        run_tile(0, 3, 2, 1'b0, 0, -1, -1, "zero_rows");
        run_tile(2, 2, 3, 1'b0, 0, -1, 4, "start_mid");
        run_tile(2, 2, 3, 1'b0, 0, 7, -1, "abort");
        run_tile(2, 2, 3, 1'b0, 0, -1, -1, "after_abort");

        // abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_start", {30'd0, beat.addr_valid, busy}, 32'd0);
        tick();
        chk("idle_abort_quiet", {29'd0, beat.addr_valid, busy, done}, 32'd0);

        for (int t = 0; t < 6; t++)
            run_tile($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 5),
                     1'($urandom), 2, -1, -1, "random");

        run_tile(300, 1, 1, 1'b1, 0, -1, -1, "row_overflow");
        run_tile(1, 600, 1, 1'b1, 0, -1, -1, "col_overflow");

        // asynchronous reset in the middle of a tile
        cfg_rows = 9'd2;
        cfg_cols = 10'd2;
        cfg_chs = 7'd3;
        cfg_stride2 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_flags", {29'd0, beat.addr_valid, busy, done}, 32'd0);
        chk("async_rst_addr", addr_word(), INV_WORD);
        tick();
        reset = 1'b1;
        tick();
        run_tile(2, 2, 3, 1'b0, 0, -1, -1, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/address_sequencer.md
Name: address_sequencer

Overview:
Controller that generates the row/col/ch address stream for one convolution tile. It feeds the lane address pipeline (address_rf) one address beat per accepted cycle. Iteration order is ch innermost, then col, then row, with a configurable spatial stride. Invalid slots use the datapath convention: address MSB = 1, remaining bits = 0.

Parameters:
row_width, 10, row address width; MSB is the invalid flag, row_width-1 payload bits
col_width, 11, col address width; MSB is the invalid flag
ch_width, 8, ch address width; MSB is the invalid flag

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  begin a tile; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE, no done pulse
cfg_rows  in  row_width-1  output rows in tile (count)
cfg_cols  in  col_width-1  output cols in tile (count)
cfg_chs  in  ch_width-1  channels in tile (count)
cfg_stride2  in  1  0 = stride 1, 1 = stride 2 (row and col)
out_ready  in  1  downstream accepts current beat
row_addr  out  row_width  row address, MSB = invalid flag
col_addr  out  col_width  col address, MSB = invalid flag
ch_addr  out  ch_width  ch address, MSB = invalid flag
addr_valid  out  1  beat valid
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at tile end

Behaviour:
- Reset (reset=0, async): state IDLE; addr_valid=0, busy=0, done=0; row/col/ch_addr = invalid pattern (MSB 1, rest 0); cfg shadow registers and counters = 0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch cfg_* into shadow registers (cfg changes mid-tile are ignored).
  - If any count is 0: go to DONE, emitting no beats.
  - Else: go to RUN; first beat (0,0,0) valid on the next cycle (1-cycle start latency).
- RUN: outputs registered; beat holds stable while addr_valid=1 and out_ready=0.
- On accept (valid & ready): advance ch; at ch = cfg_chs-1, wrap ch to 0 and advance col; at col = cfg_cols-1, wrap col and advance row. The next beat appears the following cycle, giving 1 beat/cycle at full throughput.
- Address payload: row_addr = row_idx << cfg_stride2; col_addr = col_idx << cfg_stride2; ch_addr = ch_idx. All have MSB 0 while valid. Overflow truncates modulo payload width; no flag is raised.
- Last beat (all indices at max) accepted: go to DONE; addr_valid=0; addresses return to the invalid pattern the same edge.
- DONE: assert done for exactly one cycle, then go to IDLE; busy drops with it.
- Whenever addr_valid=0, addresses hold the invalid pattern.
- start while busy: ignored.
- abort=1 in RUN or DONE: next edge goes to IDLE, addr_valid=0, addresses invalid, no done pulse. abort has priority over accept. abort in IDLE has priority over start.
- Async reset mid-tile: immediate return to the reset state; a partial tile is not resumed.
- Total beats per tile = cfg_rows*cfg_cols*cfg_chs.

Decomposition:
- Shared package holds: default widths; an invalid-address constant function (MSB 1, rest 0) per width; state encoding (IDLE=0, RUN=1, DONE=2).
- One natural sub-module: wrap_counter (parameterised width; inc, limit, clear; outputs value and at_max). Instantiate it three times and chain the at_max outputs.

Test Plan:
- Reset, then idle: after reset release → addr_valid=0, row_addr=10'h200, col_addr=11'h400, ch_addr=8'h80, busy=0.
- rows=2, cols=2, chs=3, stride1, ready=1: start → 12 beats in order (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2). Then done pulses 1 cycle after the last beat; 14 cycles start-to-done.
- Same config with stride2 → row/col addresses in {0,2}; ch unchanged; 12 beats.
- Backpressure: drop out_ready for 3 cycles at beat 5 → beat 5 held stable; no skipped or duplicated beats; done delayed by 3 cycles.
- cfg_chs=0 → no valid beats; done 2 cycles after start. start pulsed during RUN → ignored, beat count still 12.
- abort at beat 7 (with ready=1) → next cycle addr_valid=0, invalid addresses, no done. A new start then restarts from (0,0,0).
